// File: rtl/alu_packet_parser.sv
// Byte-to-operand framing stage: decodes the 4-byte header from the UART byte stream,
// reassembles little-endian 32-bit operands and hands them one at a time to the ALU.
module alu_packet_parser #(
  parameter logic [7:0]  OPCODE_ADD     = 8'h10,
  parameter logic [7:0]  OPCODE_MUL     = 8'h11,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  opcode_o,
  output logic [31:0] operand_o,
  output logic        operand_valid_o,
  input  logic        operand_ready_i,
  output logic        operand_first_o,
  output logic        operand_last_o,
  output logic        bad_opcode_o,
  output logic        bad_length_o,
  output logic        timeout_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_HDR_OP, S_HDR_RSV, S_LEN_LO, S_LEN_HI, S_DATA, S_OUT, S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic          rx_ready_q, rx_ready_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [31:0]   operand_q, operand_d;
  logic          valid_q, valid_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          bad_op_q, bad_op_d;
  logic          bad_len_q, bad_len_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [1:0]    idx_q, idx_d;
  logic [17:0]   drain_q, drain_d;
  logic [TW-1:0] timer_q, timer_d;

  logic        accept;
  logic        counting;
  logic [15:0] length;

  assign accept   = rx_valid_i && rx_ready_q;
  assign length   = {rx_data_i, len_lo_q};
  assign counting = (state_q == S_HDR_RSV) || (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA) || (state_q == S_DRAIN);

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    operand_d   = operand_q;
    valid_d     = valid_q;
    first_d     = first_q;
    last_d      = last_q;
    bad_op_d    = 1'b0;
    bad_len_d   = 1'b0;
    timeout_d   = 1'b0;
    len_lo_d    = len_lo_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    drain_d     = drain_q;
    timer_d     = timer_q;

    case (state_q)
      S_HDR_OP: if (accept) begin
        opcode_d = rx_data_i;
        state_d  = S_HDR_RSV;
      end
      S_HDR_RSV: if (accept) state_d = S_LEN_LO;
      S_LEN_LO: if (accept) begin
        len_lo_d = rx_data_i;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (accept) begin
        if (length == 16'd0) begin
          bad_len_d = 1'b1;
          state_d   = S_HDR_OP;
        end else if (opcode_q != OPCODE_ADD && opcode_q != OPCODE_MUL) begin
          bad_op_d = 1'b1;
          drain_d  = {length, 2'b00};
          state_d  = S_DRAIN;
        end else begin
          remaining_d = length;
          idx_d       = 2'd0;
          first_d     = 1'b1;
          state_d     = S_DATA;
        end
      end
      S_DATA: if (accept) begin
        operand_d[{idx_q, 3'b000} +: 8] = rx_data_i;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          valid_d     = 1'b1;
          remaining_d = remaining_q - 16'd1;
          last_d      = (remaining_q == 16'd1);
          state_d     = S_OUT;
        end
      end
      S_OUT: if (operand_ready_i) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (remaining_q == 16'd0) begin
          state_d = S_HDR_OP;
        end else begin
          first_d = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DRAIN: if (accept) begin
        drain_d = drain_q - 18'd1;
        if (drain_q == 18'd1) state_d = S_HDR_OP;
      end
      default: state_d = S_HDR_OP;
    endcase

    // An accepted byte always wins over an expiring timer.
    if (accept) begin
      timer_d = '0;
    end else if (counting) begin
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timer_d   = '0;
        timeout_d = 1'b1;
        idx_d     = 2'd0;
        operand_d = 32'd0;
        state_d   = S_HDR_OP;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (state_d == S_HDR_OP) timer_d = '0;
    rx_ready_d = (state_d != S_OUT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_HDR_OP;
      rx_ready_q  <= 1'b0;
      opcode_q    <= 8'd0;
      operand_q   <= 32'd0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      bad_op_q    <= 1'b0;
      bad_len_q   <= 1'b0;
      timeout_q   <= 1'b0;
      len_lo_q    <= 8'd0;
      remaining_q <= 16'd0;
      idx_q       <= 2'd0;
      drain_q     <= 18'd0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      opcode_q    <= opcode_d;
      operand_q   <= operand_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      bad_op_q    <= bad_op_d;
      bad_len_q   <= bad_len_d;
      timeout_q   <= timeout_d;
      len_lo_q    <= len_lo_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      timer_q     <= timer_d;
    end
  end

  assign rx_ready_o      = rx_ready_q;
  assign opcode_o        = opcode_q;
  assign operand_o       = operand_q;
  assign operand_valid_o = valid_q;
  assign operand_first_o = first_q;
  assign operand_last_o  = last_q;
  assign bad_opcode_o    = bad_op_q;
  assign bad_length_o    = bad_len_q;
  assign timeout_o       = timeout_q;
endmodule

// File: tb/tb_alu_packet_parser.sv
// Self-checking bench for alu_packet_parser: directed packets from the test plan plus
// randomized packets, compared against a packet-level model of expected operands and pulses.
module tb_alu_packet_parser;
  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [7:0]  rx_data_i = 8'd0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  opcode_o;
  logic [31:0] operand_o;
  logic        operand_valid_o;
  logic        operand_ready_i = 1'b1;
  logic        operand_first_o;
  logic        operand_last_o;
  logic        bad_opcode_o;
  logic        bad_length_o;
  logic        timeout_o;

  always #5 clk_i = ~clk_i;

  alu_packet_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .opcode_o(opcode_o), .operand_o(operand_o), .operand_valid_o(operand_valid_o),
    .operand_ready_i(operand_ready_i), .operand_first_o(operand_first_o),
    .operand_last_o(operand_last_o), .bad_opcode_o(bad_opcode_o),
    .bad_length_o(bad_length_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] data;
    logic        first;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0, bad = 0;
  int          n_badop = 0, n_badlen = 0, n_to = 0;
  int          exp_badop = 0, exp_badlen = 0, exp_to = 0;
  int          stall_left = 0, pops = 0;
  bit          stall_armed = 0, rand_ready = 0, hold_ready0 = 0, last_acc = 0;
  logic [31:0] held = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: choose ALU ready, note handshakes, advance, then score what happened.
  task automatic cycle();
    logic        hs;
    logic [31:0] d;
    logic [7:0]  o;
    logic        f, l;
    exp_t        e;
    if (hold_ready0) begin
      operand_ready_i = 1'b0;
    end else if (stall_left > 0 && operand_valid_o) begin
      operand_ready_i = 1'b0;
      check("stall_operand_hold", operand_o, held);
      check("stall_rx_ready", rx_ready_o, 0);
      stall_left--;
    end else if (stall_armed && operand_valid_o && pops == 2) begin
      stall_armed = 0;
      held = operand_o;
      stall_left = 6;
      operand_ready_i = 1'b0;
      check("stall_rx_ready", rx_ready_o, 0);
    end else begin
      operand_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    hs = operand_valid_o && operand_ready_i;
    last_acc = rx_valid_i && rx_ready_o;
    d = operand_o; o = opcode_o; f = operand_first_o; l = operand_last_o;
    @(posedge clk_i); #1;
    if (bad_opcode_o) n_badop++;
    if (bad_length_o) n_badlen++;
    if (timeout_o) n_to++;
    if (hs) begin
      pops++;
      check("operand_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("operand_data", d, e.data);
        check("operand_opcode", o, e.op);
        check("operand_first", f, e.first);
        check("operand_last", l, e.last);
      end
      check("rx_ready_after_hs", rx_ready_o, 1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid_i = 1'b1;
    rx_data_i = b;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) check("byte_accept_bound", last_acc, 1);
    rx_valid_i = 1'b0;
    rx_data_i = 8'($urandom);
  endtask

  task automatic send_packet(input logic [7:0] op, input logic [15:0] len,
                             input logic [31:0] ops[$], input bit gaps);
    bit   good;
    exp_t e;
    good = (op == 8'h10 || op == 8'h11);
    pops = 0;
    send_byte(op);
    send_byte(8'($urandom));
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    check("bad_length_pulse", bad_length_o, len == 16'd0);
    check("bad_opcode_pulse", bad_opcode_o, (len != 16'd0) && !good);
    if (len == 16'd0) exp_badlen++;
    else if (!good) exp_badop++;
    for (int i = 0; i < int'(len); i++) begin
      if (good) begin
        e.op = op; e.data = ops[i]; e.first = (i == 0); e.last = (i == int'(len) - 1);
        exp_q.push_back(e);
      end
      for (int k = 0; k < 4; k++) begin
        if (gaps) repeat ($urandom_range(0, 2)) cycle();
        send_byte(ops[i][8*k +: 8]);
      end
      if (good) check("valid_latency", operand_valid_o, 1);
    end
  endtask

  task automatic flush();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || operand_valid_o) && n < 300) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    check("operands_left", exp_q.size(), 0);
    check("bad_opcode_count", n_badop, exp_badop);
    check("bad_length_count", n_badlen, exp_badlen);
    check("timeout_count", n_to, exp_to);
  endtask

  initial begin
    logic [31:0] ops[$];
    int          to_at;
    logic [7:0]  rop;
    logic [15:0] rlen;

    // Reset state
    #2 rst_ni = 1'b0;
    #1;
    check("rst_rx_ready", rx_ready_o, 0);
    check("rst_opcode", opcode_o, 0);
    check("rst_operand", operand_o, 0);
    check("rst_valid", operand_valid_o, 0);
    check("rst_first", operand_first_o, 0);
    check("rst_last", operand_last_o, 0);
    check("rst_bad_op", bad_opcode_o, 0);
    check("rst_bad_len", bad_length_o, 0);
    check("rst_timeout", timeout_o, 0);
    repeat (2) cycle();
    rst_ni = 1'b1;
    cycle();
    check("rx_ready_after_reset", rx_ready_o, 1);

    // Add packet of two operands
    ops = '{32'h1, 32'h2};
    send_packet(8'h10, 16'd2, ops, 0);
    flush();
    $display("add packet done: total=%0d bad=%0d", total, bad);

    // Multiply packet, 7-cycle stall on operand 3
    ops = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    stall_armed = 1;
    send_packet(8'h11, 16'd5, ops, 0);
    flush();
    $display("mul packet with stall done: total=%0d bad=%0d", total, bad);

    // Bad opcode then valid add
    ops = '{32'hCAFEF00D};
    send_packet(8'h22, 16'd1, ops, 0);
    ops = '{32'h3, 32'h4};
    send_packet(8'h10, 16'd2, ops, 0);
    flush();
    $display("bad opcode packet done: total=%0d bad=%0d", total, bad);

    // Zero length then valid packet
    ops = '{};
    send_packet(8'h10, 16'd0, ops, 0);
    ops = '{32'h89ABCDEF};
    send_packet(8'h11, 16'd1, ops, 0);
    flush();
    $display("zero length packet done: total=%0d bad=%0d", total, bad);

    // Stall mid-operand until the timeout fires
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
    to_at = -1;
    for (int k = 1; k <= 24; k++) begin
      cycle();
      if (timeout_o && to_at < 0) to_at = k;
    end
    exp_to++;
    check("timeout_delay", to_at, 16);
    ops = '{32'h0BADBEEF};
    send_packet(8'h10, 16'd1, ops, 0);
    flush();
    $display("timeout packet done: total=%0d bad=%0d", total, bad);

    // Reset while an operand is waiting in OUT
    hold_ready0 = 1;
    ops = '{32'hDEADBEEF};
    send_packet(8'h11, 16'd1, ops, 0);
    cycle(); cycle();
    check("pre_reset_valid", operand_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_valid", operand_valid_o, 0);
    check("midrst_operand", operand_o, 0);
    check("midrst_opcode", opcode_o, 0);
    check("midrst_rx_ready", rx_ready_o, 0);
    check("midrst_first", operand_first_o, 0);
    check("midrst_last", operand_last_o, 0);
    exp_q.delete();
    hold_ready0 = 0;
    repeat (2) cycle();
    rst_ni = 1'b1;
    cycle();
    check("rx_ready_after_midrst", rx_ready_o, 1);
    ops = '{32'h11223344, 32'h55667788};
    send_packet(8'h10, 16'd2, ops, 0);
    flush();
    $display("reset in OUT done: total=%0d bad=%0d", total, bad);

    // Randomized packets with random gaps and random ALU backpressure
    rand_ready = 1;
    for (int p = 0; p < 12; p++) begin
      case ($urandom_range(0, 3))
        0: rop = 8'h10;
        1: rop = 8'h11;
        default: rop = 8'($urandom_range(8'h12, 8'hFF));
      endcase
      rlen = 16'($urandom_range(0, 4));
      ops = '{};
      for (int i = 0; i < int'(rlen); i++) ops.push_back($urandom);
      send_packet(rop, rlen, ops, 1);
      $display("random packet %0d op=%0h len=%0d: total=%0d bad=%0d", p, rop, rlen, total, bad);
    end
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
